imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 107 ++++++++++
 tb/tb_imem_loader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
//==============================================================================
// Module      : imem_loader
// Description : Copies DEPTH words from a synchronous boot ROM into instruction
//               memory after reset, then enables the CPU run switch.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module imem_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              running_switch,
    input  logic              reload,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              load_done,
    output logic              cpu_run,
    output logic [ADDR_W:0]   word_count,
    output logic [31:0]       checksum
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    state_t            w_next;
    logic              w_enter_load;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_wr_valid;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_cpu_run;
    logic [ADDR_W:0]   r_count;
    logic [31:0]       r_sum;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = S_LOAD;
            S_LOAD:  if (r_ptr == c_last_addr) w_next = S_DRAIN;
            S_DRAIN: w_next = S_DONE;
            S_DONE:  if (reload) w_next = S_LOAD;
            default: w_next = S_IDLE;
        endcase
        w_enter_load = (w_next == S_LOAD) && (r_state != S_LOAD);
    end

    // The write stage trails the ROM read by one cycle to match ROM latency.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_cpu_run  <= 1'b0;
            r_count    <= '0;
            r_sum      <= '0;
        end else begin
            r_state    <= w_next;
            r_wr_valid <= (r_state == S_LOAD);
            if (r_state == S_LOAD) begin
                r_wr_addr <= r_ptr;
            end

            if (w_enter_load) begin
                r_ptr <= '0;
            end else if ((r_state == S_LOAD) && (r_ptr != c_last_addr)) begin
                r_ptr <= r_ptr + ADDR_W'(1);
            end

            if (w_enter_load) begin
                r_count <= '0;
                r_sum   <= '0;
            end else if (r_wr_valid) begin
                r_count <= r_count + (ADDR_W+1)'(1);
                r_sum   <= r_sum + rom_data;
            end

            // Staying in DONE is required so a reload drops cpu_run on its edge.
            r_cpu_run <= (r_state == S_DONE) && (w_next == S_DONE) && running_switch;
        end
    end

    assign rom_addr   = r_ptr;
    assign imem_we    = r_wr_valid;
    assign imem_addr  = r_wr_addr;
    assign imem_wdata = r_wr_valid ? rom_data : 32'd0;
    assign load_done  = (r_state == S_DONE);
    assign cpu_run    = r_cpu_run;
    assign word_count = r_count;
    assign checksum   = r_sum;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
//==============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader (DEPTH=4 and DEPTH=64).
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_imem_loader;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;
    logic running_switch;
    logic reload_a;
    logic reload_b;

    logic [1:0]  rom_addr_a;
    logic [31:0] rom_data_a;
    logic        imem_we_a;
    logic [1:0]  imem_addr_a;
    logic [31:0] imem_wdata_a;
    logic        load_done_a;
    logic        cpu_run_a;
    logic [2:0]  word_count_a;
    logic [31:0] checksum_a;

    logic [5:0]  rom_addr_b;
    logic [31:0] rom_data_b;
    logic        imem_we_b;
    logic [5:0]  imem_addr_b;
    logic [31:0] imem_wdata_b;
    logic        load_done_b;
    logic        cpu_run_b;
    logic [6:0]  word_count_b;
    logic [31:0] checksum_b;

    logic [31:0] rom_a [4];
    logic [31:0] rom_b [64];

    always @(posedge clock) rom_data_a <= rom_a[rom_addr_a];
    always @(posedge clock) rom_data_b <= rom_b[rom_addr_b];

    imem_loader #(.DEPTH(4), .ADDR_W(2)) u_dut_a (
        .clock          (clock),
        .reset          (reset),
        .running_switch (running_switch),
        .reload         (reload_a),
        .rom_addr       (rom_addr_a),
        .rom_data       (rom_data_a),
        .imem_we        (imem_we_a),
        .imem_addr      (imem_addr_a),
        .imem_wdata     (imem_wdata_a),
        .load_done      (load_done_a),
        .cpu_run        (cpu_run_a),
        .word_count     (word_count_a),
        .checksum       (checksum_a)
    );

    imem_loader u_dut_b (
        .clock          (clock),
        .reset          (reset),
        .running_switch (running_switch),
        .reload         (reload_b),
        .rom_addr       (rom_addr_b),
        .rom_data       (rom_data_b),
        .imem_we        (imem_we_b),
        .imem_addr      (imem_addr_b),
        .imem_wdata     (imem_wdata_b),
        .load_done      (load_done_b),
        .cpu_run        (cpu_run_b),
        .word_count     (word_count_b),
        .checksum       (checksum_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] w [4];
        logic        sw;
        logic [31:0] exp_cs;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_reset();
        reset    = 1'b1;
        reload_a = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_rom_addr",   64'(rom_addr_a),   64'd0);
        chk("rst_imem_we",    64'(imem_we_a),    64'd0);
        chk("rst_imem_addr",  64'(imem_addr_a),  64'd0);
        chk("rst_imem_wdata", 64'(imem_wdata_a), 64'd0);
        chk("rst_load_done",  64'(load_done_a),  64'd0);
        chk("rst_cpu_run",    64'(cpu_run_a),    64'd0);
        chk("rst_word_count", 64'(word_count_a), 64'd0);
        chk("rst_checksum",   64'(checksum_a),   64'd0);
    endtask

    // Next rising edge enters LOAD; cycle c is observed after the c-th edge.
    task automatic check_load(input int pulse_at, input logic [31:0] exp_cs);
        for (int c = 1; c <= 6; c++) begin
            @(posedge clock);
            @(negedge clock);
            reload_a = (c == pulse_at);
            if (c <= 4) chk("rom_addr", 64'(rom_addr_a), 64'(c - 1));
            chk("imem_we", 64'(imem_we_a), 64'(c >= 2 && c <= 5));
            if (c >= 2 && c <= 5) begin
                chk("imem_addr",  64'(imem_addr_a),  64'(c - 2));
                chk("imem_wdata", 64'(imem_wdata_a), 64'(rom_a[c - 2]));
            end
            chk("load_done", 64'(load_done_a), 64'(c == 6));
            chk("cpu_run_loading", 64'(cpu_run_a), 64'd0);
        end
        reload_a = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("done_cpu_run",    64'(cpu_run_a),    64'(running_switch));
        chk("done_load_done",  64'(load_done_a),  64'd1);
        chk("done_imem_we",    64'(imem_we_a),    64'd0);
        chk("done_rom_hold",   64'(rom_addr_a),   64'd3);
        chk("done_word_count", 64'(word_count_a), 64'd4);
        chk("done_checksum",   64'(checksum_a),   64'(exp_cs));
    endtask

    vec_t        vecs [5];
    logic [31:0] model_sum;

    initial begin
        reset          = 1'b1;
        running_switch = 1'b0;
        reload_a       = 1'b0;
        reload_b       = 1'b0;
        for (int i = 0; i < 64; i++) rom_b[i] = 32'(i);
        for (int i = 0; i < 4; i++) rom_a[i] = 32'd0;

        vecs[0].w = '{32'd1, 32'd2, 32'd3, 32'd4};             vecs[0].sw = 1'b0; vecs[0].exp_cs = 32'd10;
        vecs[1].w = '{32'd1, 32'd2, 32'd3, 32'd4};             vecs[1].sw = 1'b1; vecs[1].exp_cs = 32'd10;
        vecs[2].w = '{32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0};     vecs[2].sw = 1'b0; vecs[2].exp_cs = 32'd1;
        vecs[3].w = '{32'd5, 32'd5, 32'd5, 32'd5};             vecs[3].sw = 1'b1; vecs[3].exp_cs = 32'd20;
        vecs[4].w = '{32'h8000_0000, 32'h8000_0000, 32'd7, 32'd0}; vecs[4].sw = 1'b1; vecs[4].exp_cs = 32'd7;

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 4; i++) rom_a[i] = vecs[v].w[i];
            running_switch = vecs[v].sw;
            apply_reset();
            reset = 1'b0;
            check_load(0, vecs[v].exp_cs);
            if (vecs[v].sw) begin
                running_switch = 1'b0;
                @(posedge clock);
                @(negedge clock);
                chk("switch_off_cpu_run", 64'(cpu_run_a), 64'd0);
                running_switch = 1'b1;
                @(posedge clock);
                @(negedge clock);
                chk("switch_on_cpu_run", 64'(cpu_run_a), 64'd1);
            end
        end

        for (int r = 0; r < 4; r++) begin
            model_sum = 32'd0;
            for (int i = 0; i < 4; i++) begin
                rom_a[i]  = $urandom;
                model_sum = model_sum + rom_a[i];
            end
            running_switch = 1'($urandom_range(0, 1));
            apply_reset();
            reset = 1'b0;
            check_load(0, model_sum);
        end

        // Reset after the write of address 1 aborts, then a full load follows.
        rom_a = '{32'd1, 32'd2, 32'd3, 32'd4};
        running_switch = 1'b0;
        apply_reset();
        reset = 1'b0;
        repeat (3) begin
            @(posedge clock);
            @(negedge clock);
        end
        chk("abort_pre_we",   64'(imem_we_a),   64'd1);
        chk("abort_pre_addr", 64'(imem_addr_a), 64'd1);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clock);
            @(negedge clock);
            chk("abort_we", 64'(imem_we_a), 64'd0);
            chk("abort_word_count", 64'(word_count_a), 64'd0);
        end
        reset = 1'b0;
        check_load(0, 32'd10);

        // Reload from DONE with a changed ROM; a pulse during LOAD is ignored.
        running_switch = 1'b1;
        apply_reset();
        reset = 1'b0;
        check_load(0, 32'd10);
        rom_a    = '{32'd5, 32'd5, 32'd5, 32'd5};
        reload_a = 1'b1;
        check_load(3, 32'd20);

        // Default-size instance: ROM[i] = i, 64 writes, load_done after 66 cycles.
        running_switch = 1'b0;
        apply_reset();
        chk("b_rst_word_count", 64'(word_count_b), 64'd0);
        reset = 1'b0;
        begin
            int first_done = 0;
            model_sum = 32'd0;
            for (int i = 0; i < 64; i++) model_sum = model_sum + rom_b[i];
            for (int c = 1; c <= 70; c++) begin
                @(posedge clock);
                @(negedge clock);
                chk("b_imem_we", 64'(imem_we_b), 64'(c >= 2 && c <= 65));
                if (imem_we_b) begin
                    chk("b_imem_addr",  64'(imem_addr_b),  64'(c - 2));
                    chk("b_imem_wdata", 64'(imem_wdata_b), 64'(imem_addr_b));
                end
                if (load_done_b && first_done == 0) first_done = c;
            end
            chk("b_load_done_cycle", 64'(first_done), 64'd66);
            chk("b_word_count", 64'(word_count_b), 64'd64);
            chk("b_checksum", 64'(checksum_b), 64'd2016);
            chk("b_checksum_model", 64'(checksum_b), 64'(model_sum));
            chk("b_cpu_run", 64'(cpu_run_b), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
